// File: rtl/vreg_sar_controller_pkg.sv
// Shared types and constants for the VREG successive-approximation controller.
package vreg_ctrl_pkg;

  localparam int CODE_W = 9;
  localparam int OUT_W  = 7;

  localparam logic [CODE_W-1:0] VREG_MID = 9'h100;

  typedef enum logic [1:0] {
    IDLE,
    SAR,
    TRACK
  } state_t;

endpackage

// File: rtl/vreg_sar_controller_if.sv
// Control/measurement bundle between the loop controller and its surroundings.
interface vreg_sar_controller_if;
  import vreg_ctrl_pkg::*;

  logic              enable;
  logic [OUT_W-1:0]  target;
  logic [OUT_W-1:0]  meas;
  logic [CODE_W-1:0] vreg;
  logic              busy;
  logic              locked;

  // master: system/plant side; slave: the controller
  modport master (output enable, target, meas, input vreg, busy, locked);
  modport slave  (input enable, target, meas, output vreg, busy, locked);

endinterface

// File: rtl/vreg_sar_controller_settle_timer.sv
// Settle timer: loads SETTLE_CYCLES-1 and counts down to 0; done flags the last cycle.
module settle_timer #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  output logic o_done
);

  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= RELOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/vreg_sar_controller.sv
// VREG loop controller: SAR search for the target code, then +/-1 LSB tracking with lock.
module vreg_sar_controller
  import vreg_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int HYST          = 1,
  parameter int LOCK_COUNT    = 4,
  parameter int RESEARCH_THR  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vreg_sar_controller_if.slave bus
);

  localparam logic signed [7:0] HYST_S = 8'(HYST);
  localparam logic signed [7:0] RTHR_S = 8'(RESEARCH_THR);
  localparam logic [3:0]        LOCK_N = 4'(LOCK_COUNT);

  state_t            r_state, w_state_nxt;
  logic [CODE_W-1:0] r_vreg,  w_vreg_nxt;
  logic [3:0]        r_ptr,   w_ptr_nxt;
  logic [3:0]        r_cnt,   w_cnt_nxt;
  logic [3:0]        w_ptr_dec;
  logic              w_load;
  logic              w_done;
  logic signed [7:0] w_err;
  logic signed [7:0] w_abs;

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .o_done  (w_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_vreg  <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vreg  <= w_vreg_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_vreg_nxt  = r_vreg;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_ptr_dec   = r_ptr - 4'd1;
    w_err       = $signed({1'b0, bus.meas} - {1'b0, bus.target});
    w_abs       = w_err[7] ? -w_err : w_err;

    // Disable dominates any evaluation due on the same edge.
    if (!bus.enable) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = SAR;
          w_vreg_nxt  = VREG_MID;
          w_ptr_nxt   = 4'd8;
          w_cnt_nxt   = '0;
          w_load      = 1'b1;
        end
        SAR: begin
          if (w_done) begin
            w_load    = 1'b1;
            w_cnt_nxt = '0;
            if (bus.meas > bus.target) w_vreg_nxt[r_ptr] = 1'b0;
            if (r_ptr != 4'd0) begin
              w_vreg_nxt[w_ptr_dec] = 1'b1;
              w_ptr_nxt             = w_ptr_dec;
            end else begin
              w_state_nxt = TRACK;
            end
          end
        end
        TRACK: begin
          if (w_done) begin
            w_load = 1'b1;
            if (w_abs > RTHR_S) begin
              w_state_nxt = SAR;
              w_vreg_nxt  = VREG_MID;
              w_ptr_nxt   = 4'd8;
              w_cnt_nxt   = '0;
            end else if (w_err > HYST_S) begin
              w_cnt_nxt = '0;
              if (r_vreg != '0) w_vreg_nxt = r_vreg - 9'd1;
            end else if (w_err < -HYST_S) begin
              w_cnt_nxt = '0;
              if (r_vreg != '1) w_vreg_nxt = r_vreg + 9'd1;
            end else if (r_cnt != LOCK_N) begin
              w_cnt_nxt = r_cnt + 4'd1;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign bus.vreg   = r_vreg;
  assign bus.busy   = (r_state == SAR);
  assign bus.locked = (r_cnt == LOCK_N);

endmodule
